// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_pkg
//  Description : Shared definitions for the pipeline hazard controller:
//                operand forwarding select encodings, hazard FSM state
//                encoding and the default event-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Default width of the stall / annul event counters.
    localparam int c_CNT_W_DEFAULT = 16;

    // Operand source select encodings.
    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_FWD_EX  = 2'b01;
    localparam logic [1:0] c_FWD_MEM = 2'b10;
    localparam logic [1:0] c_FWD_WB  = 2'b11;

    // Hazard FSM state encoding.
    localparam logic [0:0] c_ST_RUN    = 1'b0;
    localparam logic [0:0] c_ST_BUBBLE = 1'b1;

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : Forwarding source selection for a single ID operand.
//                Compares the source register field against the destination
//                of the EX, MEM and WB stages, youngest stage first.
//  Ports       : src             - source register field of the ID operand
//                ex_rd/ex_en     - EX destination and write enable
//                mem_rd/mem_en   - MEM destination and write enable
//                wb_rd/wb_en     - WB destination and write enable
//                sel             - 2-bit source select (RF/EX/MEM/WB)
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] ex_rd,
    input  logic       ex_en,
    input  logic [4:0] mem_rd,
    input  logic       mem_en,
    input  logic [4:0] wb_rd,
    input  logic       wb_en,
    output logic [1:0] sel
);

    // A matching rd necessarily equals src, so gating on src != 0 also
    // covers the rd != 0 condition: register 0 is never forwarded.
    always_comb begin
        sel = c_FWD_RF;
        if (src != 5'd0) begin
            if (ex_en && (ex_rd == src)) begin
                sel = c_FWD_EX;
            end else if (mem_en && (mem_rd == src)) begin
                sel = c_FWD_MEM;
            end else if (wb_en && (wb_rd == src)) begin
                sel = c_FWD_WB;
            end
        end
    end

endmodule : fwd_select
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Hazard control for a five-stage pipeline. Produces operand
//                forwarding selects, inserts a single bubble on a load-use
//                hazard, clears IF/ID for annulling branches, and counts
//                stall and annul events in saturating counters.
//  Ports       : Clk, R (async active-low reset)
//                ID_rs1/ID_rs2, ID_use_rs1/ID_use_rs2   - ID operands
//                EX/MEM/WB _rd, _RF_enable                - stage writers
//                EX_load_instr                            - EX holds a load
//                ID_B_instr, ID_29_a, ID_branch_always,
//                cond_true                                - branch in ID
//                fwd_sel_a/fwd_sel_b                      - operand selects
//                LE_PC, LE_IF_ID                          - load enables
//                S                                        - bubble select
//                IF_ID_clr                                - annul IF/ID
//                stall_count, annul_count                 - event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             R,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       EX_rd,
    input  logic [4:0]       MEM_rd,
    input  logic [4:0]       WB_rd,
    input  logic             EX_RF_enable,
    input  logic             MEM_RF_enable,
    input  logic             WB_RF_enable,
    input  logic             EX_load_instr,
    input  logic             ID_B_instr,
    input  logic             ID_29_a,
    input  logic             ID_branch_always,
    input  logic             cond_true,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             LE_PC,
    output logic             LE_IF_ID,
    output logic             S,
    output logic             IF_ID_clr,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] annul_count
);

    logic [1:0]       w_sel_a;
    logic [1:0]       w_sel_b;
    logic             w_load_use;
    logic             w_annul;
    logic             w_stall;
    logic             w_annul_evt;
    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_annul_count;

    // ------------------------------------------------------------------
    // Forwarding: one selector per operand
    // ------------------------------------------------------------------
    fwd_select u_fwd_a (
        .src    (ID_rs1),
        .ex_rd  (EX_rd),
        .ex_en  (EX_RF_enable),
        .mem_rd (MEM_rd),
        .mem_en (MEM_RF_enable),
        .wb_rd  (WB_rd),
        .wb_en  (WB_RF_enable),
        .sel    (w_sel_a)
    );

    fwd_select u_fwd_b (
        .src    (ID_rs2),
        .ex_rd  (EX_rd),
        .ex_en  (EX_RF_enable),
        .mem_rd (MEM_rd),
        .mem_en (MEM_RF_enable),
        .wb_rd  (WB_rd),
        .wb_en  (WB_RF_enable),
        .sel    (w_sel_b)
    );

    // ------------------------------------------------------------------
    // Hazard and annul detection
    // ------------------------------------------------------------------
    assign w_load_use = EX_load_instr && EX_RF_enable && (EX_rd != 5'd0) &&
                        ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                         (ID_use_rs2 && (ID_rs2 == EX_rd)));

    assign w_annul = ID_B_instr && ID_29_a && (!cond_true || ID_branch_always);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. BUBBLE always lasts a single cycle, so a
    // load-use costs exactly one bubble even if the hazard inputs linger.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (w_load_use) begin
                    w_state_next = c_ST_BUBBLE;
                end
            end
            c_ST_BUBBLE: begin
                w_state_next = c_ST_RUN;
            end
            default: begin
                w_state_next = c_ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            c_ST_RUN:    w_stall = w_load_use;
            c_ST_BUBBLE: w_stall = 1'b0;
            default:     w_stall = 1'b0;
        endcase
    end

    // A stall holds IF/ID, so the branch is re-presented next cycle and the
    // annul is taken then; annulling now would lose the held instruction.
    assign w_annul_evt = w_annul && !w_stall;

    // Reset overrides the visible controls: the pipeline sees a bubble and
    // RF-sourced operands while R is low.
    always_comb begin
        LE_PC     = !w_stall;
        LE_IF_ID  = !w_stall;
        S         = w_stall;
        IF_ID_clr = w_annul_evt;
        fwd_sel_a = w_sel_a;
        fwd_sel_b = w_sel_b;
        if (!R) begin
            LE_PC     = 1'b1;
            LE_IF_ID  = 1'b1;
            S         = 1'b1;
            IF_ID_clr = 1'b0;
            fwd_sel_a = c_FWD_RF;
            fwd_sel_b = c_FWD_RF;
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters. A stall in RUN is exactly the
    // RUN->BUBBLE transition.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            r_annul_count <= '0;
        end else if (w_annul_evt && (r_annul_count != {CNT_W{1'b1}})) begin
            r_annul_count <= r_annul_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;
    assign annul_count = r_annul_count;

endmodule : pipeline_hazard_ctrl
`default_nettype wire
